// File: rtl/mem_responder.sv
// Bus-side memory target: decodes an address window, inserts programmable wait states,
// returns read data with an output enable and commits exactly one byte per write strobe.
module mem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_bus,
  input  logic        mem_cs,
  input  logic        mem_oe,
  input  logic        mem_we,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        mem_rdy,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD} state_t;

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [16:0] WIN      = 17'(1) << ADDR_W;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [7:0]        mem [DEPTH];
  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] a_lat, a_lat_nx;
  logic [15:0]       a_req, a_req_nx;
  logic              oe_nx, rdy_nx, err_nx;
  logic              load_dout, wr_en;
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              hit;

  // The lower-bound test stops windows near 16'hFFFF from aliasing onto low addresses
  assign offset = addr_bus - BASE_ADDR;
  assign idx    = offset[ADDR_W-1:0];
  assign hit    = mem_cs && (addr_bus >= BASE_ADDR) && ({1'b0, offset} < WIN);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    a_lat_nx  = a_lat;
    a_req_nx  = a_req;
    oe_nx     = 1'b0;
    rdy_nx    = 1'b0;
    err_nx    = bus_err;
    load_dout = 1'b0;
    rd_idx    = a_lat;
    wr_en     = 1'b0;
    wr_idx    = a_lat;
    unique case (state)
      IDLE: begin
        if (hit && mem_oe && mem_we) begin
          err_nx = 1'b1;
        end else if (hit && mem_oe) begin
          a_lat_nx = idx;
          a_req_nx = addr_bus;
          if (WAIT_STATES == 0) begin
            state_nx  = RD_DRIVE;
            load_dout = 1'b1;
            rd_idx    = idx;
            oe_nx     = 1'b1;
            rdy_nx    = 1'b1;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end else if (hit && mem_we) begin
          a_lat_nx = idx;
          a_req_nx = addr_bus;
          if (WAIT_STATES == 0) begin
            state_nx = WR_HOLD;
            wr_en    = 1'b1;
            wr_idx   = idx;
            rdy_nx   = 1'b1;
          end else begin
            state_nx = WR_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      RD_WAIT: begin
        if (!(mem_cs && mem_oe)) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx  = RD_DRIVE;
          load_dout = 1'b1;
          oe_nx     = 1'b1;
          rdy_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RD_DRIVE: begin
        // An address change drops the bus for one cycle; IDLE then re-decodes it as a new read
        if (!(mem_cs && mem_oe) || (addr_bus != a_req)) begin
          state_nx = IDLE;
        end else begin
          oe_nx  = 1'b1;
          rdy_nx = 1'b1;
        end
      end
      WR_WAIT: begin
        if (!(mem_cs && mem_we)) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = WR_HOLD;
          wr_en    = 1'b1;
          rdy_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        if (!(mem_cs && mem_we)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      data_oe  <= 1'b0;
      mem_rdy  <= 1'b0;
      bus_err  <= 1'b0;
      data_out <= 8'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      data_oe <= oe_nx;
      mem_rdy <= rdy_nx;
      bus_err <= err_nx;
      if (load_dout) data_out <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    a_lat <= a_lat_nx;
    a_req <= a_req_nx;
  end

  // RAM is never reset; a write is suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem[wr_idx] <= data_in;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: three instances cover zero/three wait states
// and an offset window; a shadow memory supplies expected read data.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_bus = 16'h0000;
  logic        mem_oe = 1'b0;
  logic        mem_we = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        cs   [3];
  logic [7:0]  dout [3];
  logic        doe  [3];
  logic        rdy  [3];
  logic        err  [3];

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  model [3][256];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_exp;

  always #5 clk = ~clk;

  mem_responder #(.BASE_ADDR(16'h0000), .ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .mem_cs(cs[0]), .mem_oe(mem_oe),
    .mem_we(mem_we), .data_in(data_in), .data_out(dout[0]), .data_oe(doe[0]),
    .mem_rdy(rdy[0]), .bus_err(err[0]));

  mem_responder #(.BASE_ADDR(16'h0000), .ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .mem_cs(cs[1]), .mem_oe(mem_oe),
    .mem_we(mem_we), .data_in(data_in), .data_out(dout[1]), .data_oe(doe[1]),
    .mem_rdy(rdy[1]), .bus_err(err[1]));

  mem_responder #(.BASE_ADDR(16'hC000), .ADDR_W(8), .WAIT_STATES(0)) u_hi (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .mem_cs(cs[2]), .mem_oe(mem_oe),
    .mem_we(mem_we), .data_in(data_in), .data_out(dout[2]), .data_oe(doe[2]),
    .mem_rdy(rdy[2]), .bus_err(err[2]));

  function automatic logic [15:0] base_of(input int d);
    return (d == 2) ? 16'hC000 : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int d, input logic [15:0] a, input logic [7:0] v,
                    input int hold, input int exp_pulses, input string tag);
    int pulses = 0;
    addr_bus = a;
    data_in  = v;
    mem_we   = 1'b1;
    cs[d]    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rdy[d]) pulses++;
    end
    mem_we = 1'b0;
    cs[d]  = 1'b0;
    tick();
    if (exp_pulses > 0) model[d][8'(a - base_of(d))] = v;
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  task automatic rd(input int d, input logic [15:0] a, input int exp_lat, input string tag);
    int lat = 0;
    exp_q.push_back(model[d][8'(a - base_of(d))]);
    addr_bus = a;
    mem_oe   = 1'b1;
    cs[d]    = 1'b1;
    do begin
      tick();
      lat++;
    end while (!doe[d] && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    last_exp = exp_q.pop_front();
    check({tag, "_data"}, 32'(dout[d]), 32'(last_exp));
    check({tag, "_rdy"}, 32'(rdy[d]), 32'd1);
  endtask

  task automatic rd_end(input int d, input string tag);
    mem_oe = 1'b0;
    cs[d]  = 1'b0;
    tick();
    check({tag, "_oe"}, 32'(doe[d]), 32'd0);
    check({tag, "_rdy"}, 32'(rdy[d]), 32'd0);
    check({tag, "_hold"}, 32'(dout[d]), 32'(last_exp));
  endtask

  task automatic rd_miss(input int d, input logic [15:0] a, input string tag);
    logic seen = 1'b0;
    addr_bus = a;
    mem_oe   = 1'b1;
    cs[d]    = 1'b1;
    repeat (6) begin
      tick();
      if (doe[d] || rdy[d]) seen = 1'b1;
    end
    mem_oe = 1'b0;
    cs[d]  = 1'b0;
    tick();
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) cs[i] = 1'b0;

    // Reset state of every instance
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_oe%0d", i), 32'(doe[i]), 32'd0);
      check($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      check($sformatf("rst_dout%0d", i), 32'(dout[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Zero-wait read
    wr(0, 16'h0005, 8'hA5, 5, 1, "pre05");
    wr(0, 16'h0006, 8'h11, 5, 1, "pre06");
    rd(0, 16'h0005, 1, "t1");
    rd_end(0, "t1_end");

    // Three wait states: data_oe rises on the fourth edge
    wr(1, 16'h0010, 8'h3C, 6, 1, "pre10");
    rd(1, 16'h0010, 4, "t2");
    rd_end(1, "t2_end");

    // One commit per long write strobe, then read back
    wr(0, 16'h0020, 8'h7E, 5, 1, "t3_wr");
    rd(0, 16'h0020, 1, "t3_rb");
    rd_end(0, "t3_end");

    // Window edges of an offset window
    wr(2, 16'hC0FF, 8'h5A, 5, 1, "pre_c0ff");
    wr(2, 16'hC100, 8'hEE, 5, 0, "t4_wmiss");
    rd_miss(2, 16'hBFFF, "t4_miss_lo");
    rd_miss(2, 16'hC100, "t4_miss_hi");
    rd(2, 16'hC0FF, 1, "t4_hit");
    rd_end(2, "t4_end");

    // Address change while driving
    rd(0, 16'h0005, 1, "t5a");
    exp_q.push_back(model[0][8'h06]);
    addr_bus = 16'h0006;
    tick();
    check("t5_drop", 32'(doe[0]), 32'd0);
    tick();
    check("t5_reoe", 32'(doe[0]), 32'd1);
    last_exp = exp_q.pop_front();
    check("t5_data", 32'(dout[0]), 32'(last_exp));
    rd_end(0, "t5_end");

    // oe and we together: sticky error, no access
    addr_bus = 16'h0020;
    data_in  = 8'h55;
    mem_oe   = 1'b1;
    mem_we   = 1'b1;
    cs[0]    = 1'b1;
    tick();
    check("t6_err", 32'(err[0]), 32'd1);
    check("t6_no_oe", 32'(doe[0]), 32'd0);
    mem_oe = 1'b0;
    mem_we = 1'b0;
    cs[0]  = 1'b0;
    tick(2);
    check("t6_sticky", 32'(err[0]), 32'd1);
    rd(0, 16'h0020, 1, "t6_rb");
    rd_end(0, "t6_rb_end");

    // Reset during a pending write discards it
    addr_bus = 16'h0010;
    data_in  = 8'h99;
    mem_we   = 1'b1;
    cs[1]    = 1'b1;
    tick(2);
    check("t6_wait_rdy", 32'(rdy[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdy", 32'(rdy[1]), 32'd0);
    check("t6_rst_oe", 32'(doe[1]), 32'd0);
    check("t6_rst_err", 32'(err[0]), 32'd0);
    check("t6_rst_dout", 32'(dout[1]), 32'd0);
    mem_we = 1'b0;
    cs[1]  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(1, 16'h0010, 4, "t6_keep");
    rd_end(1, "t6_keep_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
